ptw_arb: RTL and testbench

PTW_ARB -- requirements
Module: ptw_arb

---
 rtl/ptw_arb_pkg.sv | 13 +
 rtl/ptw_rr2.sv | 34 +++
 rtl/ptw_arb.sv | 138 +++++++++++++
 tb/tb_ptw_arb.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ptw_arb_pkg.sv
// ptw_arb_pkg: shared widths and requester IDs for the page-table-walker
// arbiter. Imported by ptw_arb and ptw_rr2.
package ptw_arb_pkg;

  localparam int PTW_ADDR_W = 64;
  localparam int PTW_TAG_W  = 27;
  localparam int PTW_PTE_W  = 64;

  // Requester IDs; also the bit index of each requester in the picker vectors.
  localparam logic PTW_ID_ITLB = 1'b0;
  localparam logic PTW_ID_DTLB = 1'b1;

endpackage

// File: rtl/ptw_rr2.sv
// ptw_rr2: 2-way round-robin picker.
//   i_valid[1:0]  request vector (bit = requester ID)
//   i_advance     a grant was taken this cycle; move the pointer
//   o_grant[1:0]  one-hot grant (zero when nothing is valid)
// The pointer names the requester favoured on a tie. It changes only on
// advance, and then points at whichever requester was *not* just granted.
module ptw_rr2
  import ptw_arb_pkg::*;
#(
  parameter bit RESET_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_valid,
  input  logic       i_advance,
  output logic [1:0] o_grant
);

  logic r_prio;

  always_comb begin
    o_grant    = 2'b00;
    o_grant[0] = i_valid[0] & (~i_valid[1] | (r_prio == PTW_ID_ITLB));
    o_grant[1] = i_valid[1] & (~i_valid[0] | (r_prio == PTW_ID_DTLB));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_prio <= RESET_PRIO;
    else if (i_advance)
      r_prio <= o_grant[0] ? PTW_ID_DTLB : PTW_ID_ITLB;
  end

endmodule

// File: rtl/ptw_arb.sv
// ptw_arb: arbitrates ITLB and DTLB misses onto a single page-table walker.
// One walk at a time: IDLE (grant) -> LAUNCH (ptw_req_valid pulse) ->
// WAIT (for the walker fill) -> RESP (owner's resp_valid pulse) -> IDLE.
// Ports:
//   clk, rst                               clock, async active-high reset
//   itlb_req_* / dtlb_req_*                miss request handshakes (ready is
//                                          a 1-cycle grant pulse in IDLE)
//   itlb_resp_valid, dtlb_resp_valid       per-requester completion pulse
//   resp_tag, resp_pte                     shared walk result
//   ptw_req_*                              walker request, held for the walk
//   ptw_new_pte_req/_tag/_pte              walker fill
//   sfence_req / sfence_done               drain handshake
module ptw_arb
  import ptw_arb_pkg::*;
#(
  parameter bit RESET_PRIO = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  itlb_req_valid,
  input  logic [PTW_ADDR_W-1:0] itlb_req_addr,
  output logic                  itlb_req_ready,
  input  logic                  dtlb_req_valid,
  input  logic [PTW_ADDR_W-1:0] dtlb_req_addr,
  input  logic                  dtlb_req_is_store,
  output logic                  dtlb_req_ready,
  output logic                  itlb_resp_valid,
  output logic                  dtlb_resp_valid,
  output logic [PTW_TAG_W-1:0]  resp_tag,
  output logic [PTW_PTE_W-1:0]  resp_pte,
  output logic [PTW_ADDR_W-1:0] ptw_req_addr,
  output logic                  ptw_req_valid,
  output logic                  ptw_req_is_execute,
  output logic                  ptw_req_is_store,
  input  logic                  ptw_new_pte_req,
  input  logic [PTW_TAG_W-1:0]  ptw_new_tag,
  input  logic [PTW_PTE_W-1:0]  ptw_new_pte,
  input  logic                  sfence_req,
  output logic                  sfence_done
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

  state_t                r_state;
  logic                  r_owner;
  logic [PTW_ADDR_W-1:0] r_addr;
  logic                  r_is_exec;
  logic                  r_is_store;
  logic                  r_ptw_valid;
  logic                  r_itlb_resp;
  logic                  r_dtlb_resp;
  logic [PTW_TAG_W-1:0]  r_tag;
  logic [PTW_PTE_W-1:0]  r_pte;
  logic                  r_sfence_done;

  logic       w_can_grant;
  logic [1:0] w_req;
  logic [1:0] w_grant;
  logic       w_next_idle;

  // sfence only blocks new grants; a walk already past IDLE runs to RESP.
  assign w_can_grant = (r_state == S_IDLE) && !sfence_req;
  assign w_req       = {dtlb_req_valid, itlb_req_valid} & {2{w_can_grant}};

  ptw_rr2 #(.RESET_PRIO(RESET_PRIO)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (w_req),
    .i_advance (|w_grant),
    .o_grant   (w_grant)
  );

  // Ready is the grant itself, so the address is latched in the same cycle
  // the requester sees ready and a requester that drops valid is never taken.
  assign itlb_req_ready = w_grant[PTW_ID_ITLB];
  assign dtlb_req_ready = w_grant[PTW_ID_DTLB];

  // With sfence high no grant can happen, so IDLE and RESP both lead to IDLE.
  assign w_next_idle = (r_state == S_IDLE) || (r_state == S_RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_owner       <= PTW_ID_ITLB;
      r_addr        <= '0;
      r_is_exec     <= 1'b0;
      r_is_store    <= 1'b0;
      r_ptw_valid   <= 1'b0;
      r_itlb_resp   <= 1'b0;
      r_dtlb_resp   <= 1'b0;
      r_tag         <= '0;
      r_pte         <= '0;
      r_sfence_done <= 1'b0;
    end else begin
      r_ptw_valid   <= 1'b0;
      r_itlb_resp   <= 1'b0;
      r_dtlb_resp   <= 1'b0;
      // Toggling against its own value gives a pulse every 2nd cycle while
      // sfence_req is held and the arbiter sits (or lands) in IDLE.
      r_sfence_done <= sfence_req && !r_sfence_done && w_next_idle;
      unique case (r_state)
        S_IDLE: begin
          if (|w_grant) begin
            r_owner     <= w_grant[PTW_ID_DTLB] ? PTW_ID_DTLB : PTW_ID_ITLB;
            r_addr      <= w_grant[PTW_ID_DTLB] ? dtlb_req_addr : itlb_req_addr;
            r_is_exec   <= w_grant[PTW_ID_ITLB];
            r_is_store  <= w_grant[PTW_ID_DTLB] & dtlb_req_is_store;
            r_ptw_valid <= 1'b1;
            r_state     <= S_LAUNCH;
          end
        end
        S_LAUNCH: r_state <= S_WAIT;
        S_WAIT: begin
          if (ptw_new_pte_req) begin
            r_tag       <= ptw_new_tag;
            r_pte       <= ptw_new_pte;
            r_itlb_resp <= (r_owner == PTW_ID_ITLB);
            r_dtlb_resp <= (r_owner == PTW_ID_DTLB);
            r_state     <= S_RESP;
          end
        end
        S_RESP: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign itlb_resp_valid    = r_itlb_resp;
  assign dtlb_resp_valid    = r_dtlb_resp;
  assign resp_tag           = r_tag;
  assign resp_pte           = r_pte;
  assign ptw_req_addr       = r_addr;
  assign ptw_req_valid      = r_ptw_valid;
  assign ptw_req_is_execute = r_is_exec;
  assign ptw_req_is_store   = r_is_store;
  assign sfence_done        = r_sfence_done;

endmodule

// File: tb/tb_ptw_arb.sv
// tb_ptw_arb: directed scenarios plus a randomized run against a
// transaction-level reference model (who should win, when the launch,
// fill and response land, what the walker fields must hold).
module tb_ptw_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        itlb_req_valid, itlb_req_ready;
  logic [63:0] itlb_req_addr;
  logic        dtlb_req_valid, dtlb_req_is_store, dtlb_req_ready;
  logic [63:0] dtlb_req_addr;
  logic        itlb_resp_valid, dtlb_resp_valid;
  logic [26:0] resp_tag;
  logic [63:0] resp_pte;
  logic [63:0] ptw_req_addr;
  logic        ptw_req_valid, ptw_req_is_execute, ptw_req_is_store;
  logic        ptw_new_pte_req;
  logic [26:0] ptw_new_tag;
  logic [63:0] ptw_new_pte;
  logic        sfence_req, sfence_done;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ptw_arb #(.RESET_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst),
    .itlb_req_valid(itlb_req_valid), .itlb_req_addr(itlb_req_addr),
    .itlb_req_ready(itlb_req_ready),
    .dtlb_req_valid(dtlb_req_valid), .dtlb_req_addr(dtlb_req_addr),
    .dtlb_req_is_store(dtlb_req_is_store), .dtlb_req_ready(dtlb_req_ready),
    .itlb_resp_valid(itlb_resp_valid), .dtlb_resp_valid(dtlb_resp_valid),
    .resp_tag(resp_tag), .resp_pte(resp_pte),
    .ptw_req_addr(ptw_req_addr), .ptw_req_valid(ptw_req_valid),
    .ptw_req_is_execute(ptw_req_is_execute), .ptw_req_is_store(ptw_req_is_store),
    .ptw_new_pte_req(ptw_new_pte_req), .ptw_new_tag(ptw_new_tag),
    .ptw_new_pte(ptw_new_pte),
    .sfence_req(sfence_req), .sfence_done(sfence_done)
  );

  // Inputs change 1 time unit after the rising edge; outputs are sampled on
  // the falling edge.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clr_in();
    itlb_req_valid = 0; itlb_req_addr = '0;
    dtlb_req_valid = 0; dtlb_req_addr = '0; dtlb_req_is_store = 0;
    ptw_new_pte_req = 0; ptw_new_tag = '0; ptw_new_pte = '0;
    sfence_req = 0;
  endtask

  task automatic do_reset();
    rst = 1; clr_in();
    tick(); tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; clr_in();
    #3;
    checks++;
    if ({itlb_req_ready, dtlb_req_ready, itlb_resp_valid, dtlb_resp_valid,
         ptw_req_valid, ptw_req_is_execute, ptw_req_is_store, sfence_done} !== 8'h00) begin
      errs++; $display("FAIL reset_flags got=%b exp=00000000",
        {itlb_req_ready, dtlb_req_ready, itlb_resp_valid, dtlb_resp_valid,
         ptw_req_valid, ptw_req_is_execute, ptw_req_is_store, sfence_done});
    end
    checks++;
    if (resp_tag !== 27'd0) begin errs++; $display("FAIL reset_tag got=%h exp=0", resp_tag); end
    checks++;
    if (resp_pte !== 64'd0) begin errs++; $display("FAIL reset_pte got=%h exp=0", resp_pte); end
    checks++;
    if (ptw_req_addr !== 64'd0) begin errs++; $display("FAIL reset_addr got=%h exp=0", ptw_req_addr); end
    tick(); tick(); rst = 0;
  endtask

  task automatic test_itlb_only();
    logic [63:0] a;
    a = 64'h0000_0040_1234_5000;
    do_reset();
    itlb_req_valid = 1; itlb_req_addr = a;
    smp();
    checks++;
    if ({dtlb_req_ready, itlb_req_ready} !== 2'b01) begin
      errs++; $display("FAIL itlb_grant got=%b exp=01", {dtlb_req_ready, itlb_req_ready});
    end
    tick(); itlb_req_valid = 0; smp();
    checks++;
    if ({ptw_req_valid, ptw_req_is_execute, ptw_req_is_store, ptw_req_addr} !== {3'b110, a}) begin
      errs++; $display("FAIL itlb_launch got=%b%b%b %h exp=110 %h",
        ptw_req_valid, ptw_req_is_execute, ptw_req_is_store, ptw_req_addr, a);
    end
    for (int k = 1; k <= 10; k++) begin
      tick();
      ptw_new_pte_req = (k == 10);
      ptw_new_tag = 27'h0401234; ptw_new_pte = 64'h2000_04CF;
      smp();
      checks++;
      if ({ptw_req_valid, itlb_resp_valid, dtlb_resp_valid, ptw_req_addr} !== {3'b000, a}) begin
        errs++; $display("FAIL itlb_wait k=%0d got=%b%b%b %h exp=000 %h", k,
          ptw_req_valid, itlb_resp_valid, dtlb_resp_valid, ptw_req_addr, a);
      end
    end
    tick(); ptw_new_pte_req = 0; smp();
    checks++;
    if ({itlb_resp_valid, dtlb_resp_valid, ptw_req_is_execute} !== 3'b101) begin
      errs++; $display("FAIL itlb_resp got=%b%b%b exp=101",
        itlb_resp_valid, dtlb_resp_valid, ptw_req_is_execute);
    end
    checks++;
    if ({resp_tag, resp_pte} !== {27'h0401234, 64'h2000_04CF}) begin
      errs++; $display("FAIL itlb_result got=%h %h exp=0401234 20004cf", resp_tag, resp_pte);
    end
    tick(); smp();
    checks++;
    if ({itlb_resp_valid, dtlb_resp_valid} !== 2'b00) begin
      errs++; $display("FAIL itlb_resp_once got=%b%b exp=00", itlb_resp_valid, dtlb_resp_valid);
    end
  endtask

  task automatic test_both_from_reset();
    logic [63:0] ad [2];
    ad[0] = 64'h1111_0000_0000_1000;
    ad[1] = 64'h2222_0000_0000_2000;
    do_reset();
    itlb_req_valid = 1; itlb_req_addr = ad[0];
    dtlb_req_valid = 1; dtlb_req_addr = ad[1];
    smp();
    checks++;
    if ({dtlb_req_ready, itlb_req_ready} !== 2'b01) begin
      errs++; $display("FAIL both_first got=%b exp=01", {dtlb_req_ready, itlb_req_ready});
    end
    for (int w = 0; w < 2; w++) begin
      tick();
      if (w == 0) itlb_req_valid = 0; else dtlb_req_valid = 0;
      smp();
      checks++;
      if ({ptw_req_valid, ptw_req_addr} !== {1'b1, ad[w]}) begin
        errs++; $display("FAIL both_launch w=%0d got=%b %h exp=1 %h", w, ptw_req_valid, ptw_req_addr, ad[w]);
      end
      for (int k = 1; k <= 3; k++) begin
        tick(); ptw_new_pte_req = (k == 3); smp();
        checks++;
        if ({ptw_req_valid, dtlb_req_ready, itlb_req_ready, ptw_req_addr} !== {3'b000, ad[w]}) begin
          errs++; $display("FAIL both_wait w=%0d k=%0d got=%b%b%b %h exp=000 %h", w, k,
            ptw_req_valid, dtlb_req_ready, itlb_req_ready, ptw_req_addr, ad[w]);
        end
      end
      tick(); ptw_new_pte_req = 0; smp();
      checks++;
      if ({dtlb_resp_valid, itlb_resp_valid, ptw_req_addr} !== {2'(1 << w), ad[w]}) begin
        errs++; $display("FAIL both_resp w=%0d got=%b%b %h exp=%b %h", w,
          dtlb_resp_valid, itlb_resp_valid, ptw_req_addr, 2'(1 << w), ad[w]);
      end
      tick(); smp();
      checks++;
      if ({dtlb_req_ready, itlb_req_ready} !== ((w == 0) ? 2'b10 : 2'b00)) begin
        errs++; $display("FAIL both_next w=%0d got=%b", w, {dtlb_req_ready, itlb_req_ready});
      end
    end
  endtask

  task automatic test_dtlb_store();
    logic [63:0] a;
    a = 64'h0000_0000_8000_3000;
    do_reset();
    dtlb_req_valid = 1; dtlb_req_addr = a; dtlb_req_is_store = 1;
    smp();
    checks++;
    if ({dtlb_req_ready, itlb_req_ready} !== 2'b10) begin
      errs++; $display("FAIL st_grant got=%b exp=10", {dtlb_req_ready, itlb_req_ready});
    end
    // Drop is_store with valid: the walker fields must come from the latch.
    tick(); dtlb_req_valid = 0; dtlb_req_is_store = 0; smp();
    checks++;
    if ({ptw_req_valid, ptw_req_is_execute, ptw_req_is_store, ptw_req_addr} !== {3'b101, a}) begin
      errs++; $display("FAIL st_launch got=%b%b%b %h exp=101 %h",
        ptw_req_valid, ptw_req_is_execute, ptw_req_is_store, ptw_req_addr, a);
    end
    // Walker latency 5 (fill 5 cycles after launch): grant cycle g, launch
    // g+1, fill g+6, resp g+7 = grant + latency + 2, i.e. 3 cycles of overhead
    // counting grant, launch and resp.
    for (int k = 1; k <= 6; k++) begin
      tick(); ptw_new_pte_req = (k == 5); ptw_new_pte = 64'hABCD; smp();
      checks++;
      if ({dtlb_resp_valid, itlb_resp_valid} !== ((k == 6) ? 2'b10 : 2'b00)) begin
        errs++; $display("FAIL st_resp_time k=%0d got=%b%b", k, dtlb_resp_valid, itlb_resp_valid);
      end
    end
    checks++;
    if ({ptw_req_is_execute, ptw_req_is_store, resp_pte} !== {2'b01, 64'hABCD}) begin
      errs++; $display("FAIL st_hold got=%b%b %h exp=01 abcd", ptw_req_is_execute, ptw_req_is_store, resp_pte);
    end
  endtask

  task automatic test_sfence();
    do_reset();
    dtlb_req_valid = 1; dtlb_req_addr = 64'h5000;
    smp();
    tick(); dtlb_req_valid = 0; smp();   // launch
    tick(); smp();                       // walk cycle 1
    tick(); sfence_req = 1; itlb_req_valid = 1; itlb_req_addr = 64'h7000; smp();
    checks++;
    if ({itlb_req_ready, sfence_done} !== 2'b00) begin
      errs++; $display("FAIL sf_mid got=%b%b exp=00", itlb_req_ready, sfence_done);
    end
    for (int k = 1; k <= 3; k++) begin
      tick(); ptw_new_pte_req = (k == 3); smp();
      checks++;
      if ({dtlb_req_ready, itlb_req_ready, sfence_done} !== 3'b000) begin
        errs++; $display("FAIL sf_wait k=%0d got=%b%b%b", k, dtlb_req_ready, itlb_req_ready, sfence_done);
      end
    end
    tick(); ptw_new_pte_req = 0; smp();
    checks++;
    if ({dtlb_resp_valid, itlb_resp_valid, itlb_req_ready, sfence_done} !== 4'b1000) begin
      errs++; $display("FAIL sf_resp got=%b%b%b%b exp=1000",
        dtlb_resp_valid, itlb_resp_valid, itlb_req_ready, sfence_done);
    end
    // Held sfence: done pulses 1,0,1 starting the cycle after RESP.
    for (int k = 0; k < 3; k++) begin
      tick(); smp();
      checks++;
      if ({sfence_done, itlb_req_ready} !== {((k % 2) == 0), 1'b0}) begin
        errs++; $display("FAIL sf_done k=%0d got=%b%b exp=%b0", k, sfence_done, itlb_req_ready, ((k % 2) == 0));
      end
    end
    tick(); sfence_req = 0; smp();
    checks++;
    if ({itlb_req_ready, dtlb_req_ready, sfence_done} !== 3'b100) begin
      errs++; $display("FAIL sf_release got=%b%b%b exp=100", itlb_req_ready, dtlb_req_ready, sfence_done);
    end
  endtask

  task automatic test_reset_mid_walk();
    do_reset();
    itlb_req_valid = 1; itlb_req_addr = 64'h9000;
    smp();
    tick(); itlb_req_valid = 0; smp();
    tick(); smp();
    tick(); smp();
    #2 rst = 1;
    #1;
    checks++;
    if ({ptw_req_addr, resp_tag, resp_pte, itlb_resp_valid, dtlb_resp_valid, ptw_req_valid,
         ptw_req_is_execute, ptw_req_is_store, sfence_done} !== '0) begin
      errs++; $display("FAIL rst_mid got addr=%h tag=%h exec=%b", ptw_req_addr, resp_tag, ptw_req_is_execute);
    end
    tick(); tick(); rst = 0;
    for (int k = 0; k < 5; k++) begin
      smp();
      checks++;
      if ({itlb_resp_valid, dtlb_resp_valid, ptw_req_valid} !== 3'b000) begin
        errs++; $display("FAIL rst_quiet k=%0d got=%b%b%b", k, itlb_resp_valid, dtlb_resp_valid, ptw_req_valid);
      end
      tick();
    end
    dtlb_req_valid = 1; dtlb_req_addr = 64'hA000; smp();
    checks++;
    if (dtlb_req_ready !== 1'b1) begin errs++; $display("FAIL rst_regrant got=%b exp=1", dtlb_req_ready); end
    tick(); dtlb_req_valid = 0; smp();
    checks++;
    if ({ptw_req_valid, ptw_req_addr} !== {1'b1, 64'hA000}) begin
      errs++; $display("FAIL rst_relaunch got=%b %h", ptw_req_valid, ptw_req_addr);
    end
  endtask

  task automatic test_spurious();
    do_reset();
    ptw_new_pte_req = 1; ptw_new_tag = 27'h55AA; ptw_new_pte = 64'hDEAD;
    smp();
    tick(); ptw_new_pte_req = 0; smp();
    checks++;
    if ({itlb_resp_valid, dtlb_resp_valid, ptw_req_valid, resp_tag, resp_pte} !== '0) begin
      errs++; $display("FAIL spur got=%b%b%b tag=%h pte=%h", itlb_resp_valid, dtlb_resp_valid,
        ptw_req_valid, resp_tag, resp_pte);
    end
    tick(); itlb_req_valid = 1; smp();
    checks++;
    if (itlb_req_ready !== 1'b1) begin errs++; $display("FAIL spur_idle got=%b exp=1", itlb_req_ready); end
  endtask

  task automatic test_random();
    bit          iv, dv, ds, in_fl;
    logic [63:0] ia, da, e_addr;
    logic [26:0] e_tag;
    logic [63:0] e_pte;
    int          g_cyc, f_cyc, own, last, win;
    bit          e_exec, e_store;
    logic [1:0]  e_rdy, e_resp;
    do_reset();
    iv = 0; dv = 0; ds = 0; in_fl = 0; ia = '0; da = '0; e_addr = '0;
    g_cyc = -10; f_cyc = -10; own = 0; e_exec = 0; e_store = 0;
    e_tag = '0; e_pte = '0;
    last = 1;   // RESET_PRIO=0: ITLB is favoured, as if DTLB went last
    for (int c = 0; c < 800; c++) begin
      if (!iv && $urandom_range(0, 2) == 0) begin iv = 1; ia = {$urandom, $urandom}; end
      else if (iv && $urandom_range(0, 19) == 0) iv = 0;
      if (!dv && $urandom_range(0, 2) == 0) begin
        dv = 1; da = {$urandom, $urandom}; ds = 1'($urandom_range(0, 1));
      end else if (dv && $urandom_range(0, 19) == 0) dv = 0;
      itlb_req_valid = iv; itlb_req_addr = ia;
      dtlb_req_valid = dv; dtlb_req_addr = da; dtlb_req_is_store = ds;
      ptw_new_tag = 27'($urandom); ptw_new_pte = {$urandom, $urandom};
      if (in_fl && c == f_cyc) begin
        ptw_new_pte_req = 1; e_tag = ptw_new_tag; e_pte = ptw_new_pte;
      end else
        ptw_new_pte_req = ((!in_fl || c == g_cyc + 1) && $urandom_range(0, 7) == 0);
      smp();
      win = -1;
      if (!in_fl) begin
        if (iv && dv) win = 1 - last;
        else if (iv) win = 0;
        else if (dv) win = 1;
      end
      e_rdy  = (win >= 0) ? 2'(1 << win) : 2'b00;
      e_resp = (in_fl && c == f_cyc + 1) ? 2'(1 << own) : 2'b00;
      checks++;
      if ({dtlb_req_ready, itlb_req_ready} !== e_rdy) begin
        errs++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, {dtlb_req_ready, itlb_req_ready}, e_rdy);
      end
      checks++;
      if (ptw_req_valid !== (in_fl && c == g_cyc + 1)) begin
        errs++; $display("FAIL rnd_launch c=%0d got=%b", c, ptw_req_valid);
      end
      checks++;
      if ({dtlb_resp_valid, itlb_resp_valid} !== e_resp) begin
        errs++; $display("FAIL rnd_resp c=%0d got=%b exp=%b", c, {dtlb_resp_valid, itlb_resp_valid}, e_resp);
      end
      checks++;
      if (sfence_done !== 1'b0) begin errs++; $display("FAIL rnd_sfence c=%0d got=1 exp=0", c); end
      if (in_fl && c > g_cyc) begin
        checks++;
        if ({ptw_req_addr, ptw_req_is_execute, ptw_req_is_store} !== {e_addr, e_exec, e_store}) begin
          errs++; $display("FAIL rnd_fields c=%0d got=%h %b%b exp=%h %b%b", c, ptw_req_addr,
            ptw_req_is_execute, ptw_req_is_store, e_addr, e_exec, e_store);
        end
      end
      if (e_resp != 2'b00) begin
        checks++;
        if ({resp_tag, resp_pte} !== {e_tag, e_pte}) begin
          errs++; $display("FAIL rnd_result c=%0d got=%h %h exp=%h %h", c, resp_tag, resp_pte, e_tag, e_pte);
        end
        in_fl = 0;
      end
      if (win >= 0) begin
        in_fl = 1; g_cyc = c; f_cyc = c + 1 + $urandom_range(1, 6);
        own = win; last = win;
        e_addr = (win == 1) ? da : ia; e_exec = (win == 0); e_store = (win == 1) && ds;
        if (win == 0) iv = 0; else dv = 0;
      end
      tick();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; clr_in();
    test_reset();
    test_itlb_only();
    test_both_from_reset();
    test_dtlb_store();
    test_sfence();
    test_reset_mid_walk();
    test_spurious();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
